multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Multi-cycle control FSM that sequences the instruction-fetch stage and the datapath.
//   Each instruction runs as FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   The FSM drives the fetch stage's PC enable and its branch select B.
//   The PC advances exactly once per instruction, in the instruction's final state.
//   Sits between instruction/data memories (req/ready handshake), IR, register file and ALU.
// PARAMETERS
//   TIMEOUT   16   max cycles a memory req may wait for ready before ERR (>=1)
//   CNT_W     32   width of retired-instruction counter
// PORTS
//   Clock      in   1      system clock, rising edge
//   Reset      in   1      synchronous, active-high
//   Opcode     in   6      IR[31:26], valid from the cycle after IRWrite
//   Z          in   1      ALU zero flag, valid combinationally in EXEC
//   IMemRdy    in   1      instruction memory ready (data valid this cycle)
//   DMemRdy    in   1      data memory ready (read data valid / write accepted)
//   IMemReq    out  1      instruction fetch request
//   IRWrite    out  1      load IR from instruction memory
//   DMemReq    out  1      data memory request
//   MemWrite   out  1      data memory write (qualifies DMemReq)
//   ALUOp      out  2      00 add, 01 sub (beq), 10 funct-decoded (R-type)
//   ALUSrcImm  out  1      ALU B operand = sign-extended immediate
//   RegWrite   out  1      register file write strobe
//   RegDst     out  1      1: rd (R-type), 0: rt
//   MemToReg   out  1      1: write-back data from memory
//   PCWrite    out  1      PC update enable of fetch stage
//   B          out  1      branch instruction flag to fetch stage (fetch ANDs with Z)
//   Illegal    out  1      sticky error (bad opcode or memory timeout)
//   State      out  3      current state encoding (debug)
//   Retired    out  CNT_W  count of PCWrite pulses since reset, wraps
// BEHAVIOUR
//   States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 ERR=7. All outputs are combinational from state, op_q and Rdy.
//   Reset: state<=FETCH, op_q<=0, wait counter<=0, Retired<=0, Illegal<=0.
//     All strobes are 0 while Reset is high.
//     Reset mid-instruction aborts it; no PCWrite, RegWrite or MemWrite is issued.
//   FETCH: IMemReq=1.
//     IMemRdy=1: IRWrite=1 same cycle -> DECODE.
//     Otherwise wait counter +1; at TIMEOUT consecutive un-ready cycles -> ERR.
//   DECODE: op_q<=Opcode; no strobes.
//     000000 (R), 001000 (addi), 100011 (lw), 101011 (sw), 000100 (beq) -> EXEC.
//     Any other opcode -> ERR.
//   EXEC: ALUOp = R:10 / beq:01 / others:00; ALUSrcImm=1 for addi, lw, sw.
//     beq: B=1, PCWrite=1 -> FETCH (next PC = PC+4 + off<<2 if Z, else PC+4).
//     R, addi -> WB. lw, sw -> MEM.
//   MEM: DMemReq=1, MemWrite=(op_q==sw); same TIMEOUT rule as FETCH (-> ERR).
//     sw & DMemRdy: PCWrite=1 -> FETCH.
//     lw & DMemRdy -> WB.
//   WB: RegWrite=1, PCWrite=1, RegDst=(R), MemToReg=(lw) -> FETCH.
//   ERR: all strobes 0, Illegal=1; remains in ERR until Reset.
//   Wait counter clears on every state change; Rdy in the TIMEOUT-th cycle is still accepted.
//   Rdy inputs are ignored outside their own request state.
//   PCWrite is exactly one cycle per retired instruction; Retired +1 on PCWrite.
//   Cycles with Rdy immediate: beq 3, R/addi/sw 4, lw 5.
// TESTING
//   Rdy tied 1, R-type (Opcode 0) -> states 0,1,2,4; RegWrite=RegDst=PCWrite=1 in cycle 4 only.
//   beq with Z=1 then Z=0 -> B=1, PCWrite=1 in EXEC both times; Retired 0->2 after 6 cycles.
//   lw with DMemRdy low 3 cycles -> MEM held 4 cycles; WB has MemToReg=1, RegWrite=1.
//   IMemRdy held 0, TIMEOUT=16 -> ERR after 16 FETCH cycles; Illegal=1; Reset -> FETCH, Illegal=0.
//   Opcode 6'b111111 -> DECODE->ERR, no PCWrite; sw with Reset in MEM -> no MemWrite after Reset edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences instruction fetch, decode, execute, memory and
// write-back, and drives the fetch stage's PC enable and branch select.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic             Z,
  input  logic             IMemRdy,
  input  logic             DMemRdy,
  output logic             IMemReq,
  output logic             IRWrite,
  output logic             DMemReq,
  output logic             MemWrite,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcImm,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             PCWrite,
  output logic             B,
  output logic             Illegal,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] Retired
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  state_t             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;

  logic imem_req_s, ir_write_s, dmem_req_s, mem_write_s;
  logic [1:0] alu_op_s;
  logic alu_src_imm_s, reg_write_s, reg_dst_s, mem_to_reg_s, pc_write_s, b_s;
  logic wait_expired_s;

  // The zero flag is combined with B inside the fetch stage, not here.
  logic z_unused_s;
  assign z_unused_s = Z;

  assign wait_expired_s = (wait_q == WAIT_W'(TIMEOUT - 1));

  // Next-state, wait counter, counters and raw strobes.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    wait_d        = wait_q;
    imem_req_s    = 1'b0;
    ir_write_s    = 1'b0;
    dmem_req_s    = 1'b0;
    mem_write_s   = 1'b0;
    alu_op_s      = 2'b00;
    alu_src_imm_s = 1'b0;
    reg_write_s   = 1'b0;
    reg_dst_s     = 1'b0;
    mem_to_reg_s  = 1'b0;
    pc_write_s    = 1'b0;
    b_s           = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (IMemRdy) begin
          ir_write_s = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_expired_s) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        op_d = Opcode;
        case (Opcode)
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          default:                             state_d = S_ERR;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_R: begin
            alu_op_s = 2'b10;
            state_d  = S_WB;
          end
          OP_ADDI: begin
            alu_src_imm_s = 1'b1;
            state_d       = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_imm_s = 1'b1;
            state_d       = S_MEM;
          end
          OP_BEQ: begin
            alu_op_s   = 2'b01;
            b_s        = 1'b1;
            pc_write_s = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        dmem_req_s  = 1'b1;
        mem_write_s = (op_q == OP_SW);
        if (DMemRdy) begin
          if (op_q == OP_SW) begin
            pc_write_s = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired_s) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        pc_write_s   = 1'b1;
        reg_dst_s    = (op_q == OP_R);
        mem_to_reg_s = (op_q == OP_LW);
        state_d      = S_FETCH;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    if (state_d != state_q) begin
      wait_d = '0;
    end else begin
      wait_d = wait_d;
    end

    retired_d = retired_q + (pc_write_s ? CNT_W'(1) : CNT_W'(0));
    illegal_d = illegal_q | (state_d == S_ERR);
  end

  // State, latched opcode, wait counter and sticky status registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes are forced low while Reset is held so an aborted instruction has no effect.
  assign IMemReq   = imem_req_s    & ~Reset;
  assign IRWrite   = ir_write_s    & ~Reset;
  assign DMemReq   = dmem_req_s    & ~Reset;
  assign MemWrite  = mem_write_s   & ~Reset;
  assign ALUOp     = alu_op_s      & {2{~Reset}};
  assign ALUSrcImm = alu_src_imm_s & ~Reset;
  assign RegWrite  = reg_write_s   & ~Reset;
  assign RegDst    = reg_dst_s     & ~Reset;
  assign MemToReg  = mem_to_reg_s  & ~Reset;
  assign PCWrite   = pc_write_s    & ~Reset;
  assign B         = b_s           & ~Reset;
  assign Illegal   = illegal_q;
  assign State     = state_q;
  assign Retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors are queued as
// stimulus is applied and popped/compared at the following falling edge.
module tb_multicycle_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [5:0]  Opcode;
  logic        Z, IMemRdy, DMemRdy;
  logic        IMemReq, IRWrite, DMemReq, MemWrite;
  logic [1:0]  ALUOp;
  logic        ALUSrcImm, RegWrite, RegDst, MemToReg, PCWrite, B, Illegal;
  logic [2:0]  State;
  logic [31:0] Retired;

  int tests = 0;
  int fails = 0;

  logic [15:0] sb_q[$];
  string       tag_q[$];

  // Packed observation: {IMemReq,IRWrite,DMemReq,MemWrite,ALUOp,ALUSrcImm,RegWrite,
  // RegDst,MemToReg,PCWrite,B,Illegal,State}
  localparam logic [15:0] IMR = 16'h8000, IRW = 16'h4000, DMR = 16'h2000, MW  = 16'h1000;
  localparam logic [15:0] ALU_R = 16'h0800, ALU_SUB = 16'h0400, SRC = 16'h0200;
  localparam logic [15:0] RW = 16'h0100, RD = 16'h0080, M2R = 16'h0040, PCW = 16'h0020;
  localparam logic [15:0] BR = 16'h0010, ILL = 16'h0008;
  localparam logic [15:0] S_F = 16'd0, S_D = 16'd1, S_E = 16'd2, S_M = 16'd3;
  localparam logic [15:0] S_W = 16'd4, S_X = 16'd7;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BAD = 6'b111111;

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Z(Z),
    .IMemRdy(IMemRdy), .DMemRdy(DMemRdy),
    .IMemReq(IMemReq), .IRWrite(IRWrite), .DMemReq(DMemReq), .MemWrite(MemWrite),
    .ALUOp(ALUOp), .ALUSrcImm(ALUSrcImm), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .PCWrite(PCWrite), .B(B), .Illegal(Illegal),
    .State(State), .Retired(Retired)
  );

  always #5 Clock = ~Clock;

  // Queue one expected cycle, compare it at the falling edge, then advance past the clock.
  task automatic cyc(input logic [15:0] exp, input string tag);
    logic [15:0] obs;
    logic [15:0] want;
    string       t;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge Clock);
    obs  = {IMemReq, IRWrite, DMemReq, MemWrite, ALUOp, ALUSrcImm, RegWrite,
            RegDst, MemToReg, PCWrite, B, Illegal, State};
    want = sb_q.pop_front();
    t    = tag_q.pop_front();
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", t, obs, want);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_ret(input logic [31:0] exp, input string tag);
    tests++;
    assert (Retired === exp) else begin
      fails++;
      $error("FAIL %s: observed Retired %0d expected %0d", tag, Retired, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; Opcode = OP_R; Z = 1'b0; IMemRdy = 1'b1; DMemRdy = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    cyc(S_F, "reset_gated");
    chk_ret(32'd0, "reset_retired");
    Reset = 1'b0;

    // R-type with ready memories: 4 cycles
    cyc(IMR | IRW | S_F, "r_fetch");
    cyc(S_D, "r_decode");
    cyc(ALU_R | S_E, "r_exec");
    cyc(RW | RD | PCW | S_W, "r_wb");
    chk_ret(32'd1, "r_retired");

    // beq taken then not taken: both retire in EXEC
    Opcode = OP_BEQ; Z = 1'b1;
    cyc(IMR | IRW | S_F, "beq1_fetch");
    cyc(S_D, "beq1_decode");
    cyc(ALU_SUB | BR | PCW | S_E, "beq1_exec");
    Z = 1'b0;
    cyc(IMR | IRW | S_F, "beq0_fetch");
    cyc(S_D, "beq0_decode");
    cyc(ALU_SUB | BR | PCW | S_E, "beq0_exec");
    chk_ret(32'd3, "beq_retired");

    Opcode = OP_ADDI;
    cyc(IMR | IRW | S_F, "addi_fetch");
    cyc(S_D, "addi_decode");
    cyc(SRC | S_E, "addi_exec");
    cyc(RW | PCW | S_W, "addi_wb");
    chk_ret(32'd4, "addi_retired");

    // lw with three un-ready data cycles
    Opcode = OP_LW; DMemRdy = 1'b0;
    cyc(IMR | IRW | S_F, "lw_fetch");
    cyc(S_D, "lw_decode");
    cyc(SRC | S_E, "lw_exec");
    for (int i = 0; i < 3; i++) cyc(DMR | S_M, "lw_mem_wait");
    DMemRdy = 1'b1;
    cyc(DMR | S_M, "lw_mem_rdy");
    cyc(RW | M2R | PCW | S_W, "lw_wb");
    chk_ret(32'd5, "lw_retired");

    // sw after a slow fetch
    Opcode = OP_SW; IMemRdy = 1'b0;
    cyc(IMR | S_F, "sw_fetch_wait");
    cyc(IMR | S_F, "sw_fetch_wait");
    IMemRdy = 1'b1;
    cyc(IMR | IRW | S_F, "sw_fetch");
    cyc(S_D, "sw_decode");
    cyc(SRC | S_E, "sw_exec");
    cyc(DMR | MW | PCW | S_M, "sw_mem");
    chk_ret(32'd6, "sw_retired");

    // ready in the 16th waiting cycle is still accepted
    Opcode = OP_BEQ; IMemRdy = 1'b0;
    for (int i = 0; i < 15; i++) cyc(IMR | S_F, "edge_fetch_wait");
    IMemRdy = 1'b1;
    cyc(IMR | IRW | S_F, "edge_fetch_accept");
    cyc(S_D, "edge_decode");
    cyc(ALU_SUB | BR | PCW | S_E, "edge_exec");
    chk_ret(32'd7, "edge_retired");

    // 16 un-ready fetch cycles -> ERR, sticky until Reset
    IMemRdy = 1'b0;
    for (int i = 0; i < 16; i++) cyc(IMR | S_F, "to_fetch_wait");
    IMemRdy = 1'b1;
    cyc(ILL | S_X, "to_err");
    cyc(ILL | S_X, "to_err_sticky");
    chk_ret(32'd7, "to_retired");
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    chk_ret(32'd0, "to_reset_retired");

    // illegal opcode
    Opcode = OP_BAD;
    cyc(IMR | IRW | S_F, "bad_fetch_after_reset");
    cyc(S_D, "bad_decode");
    cyc(ILL | S_X, "bad_err");
    chk_ret(32'd0, "bad_retired");
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    // sw aborted by Reset while in MEM
    Opcode = OP_SW;
    cyc(IMR | IRW | S_F, "swr_fetch");
    cyc(S_D, "swr_decode");
    cyc(SRC | S_E, "swr_exec");
    Reset = 1'b1;
    cyc(S_M, "swr_mem_reset");
    Reset = 1'b0;
    cyc(IMR | IRW | S_F, "swr_after_reset");
    chk_ret(32'd0, "swr_retired");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
